// File: rtl/cv32e40p_fpu_lat_pipe.sv
// FPU result-latency pipeline: per-class delay lines merged onto one writeback port.
// Optional collision-stall counter enabled by CV32E40P_FPU_LAT_STALLCNT_EN.
module cv32e40p_fpu_lat_pipe #(
  parameter int unsigned ADDMUL_LAT = 0,
  parameter int unsigned OTHERS_LAT = 0,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned FLAGS_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_class_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic [FLAGS_W-1:0] in_flags_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [TAG_W-1:0]   out_tag_o,
  output logic [DATA_W-1:0]  out_data_o,
  output logic [FLAGS_W-1:0] out_flags_o,
  input  logic [TAG_W-1:0]   hazard_tag_i,
  output logic               hazard_o,
  output logic               busy_o,
  output logic [31:0]        stall_cnt_o
);

  // The longer pipeline always holds the older op, so it wins a collision.
  localparam bit OTH_WINS = OTHERS_LAT > ADDMUL_LAT;

  logic [1:0]         head_v;
  logic [1:0]         grant;
  logic [1:0]         rdy;
  logic [1:0]         hit;
  logic [1:0]         live;
  logic               collide;
  logic [TAG_W-1:0]   head_tag   [2];
  logic [DATA_W-1:0]  head_data  [2];
  logic [FLAGS_W-1:0] head_flags [2];

  for (genvar c = 0; c < 2; c++) begin : g_cls
    localparam int unsigned LAT = (c == 0) ? ADDMUL_LAT : OTHERS_LAT;
    logic sel;
    assign sel = in_valid_i && (in_class_i == 1'(c));

    if (LAT == 0) begin : g_comb
      assign head_v[c]     = sel;
      assign head_tag[c]   = in_tag_i;
      assign head_data[c]  = in_data_i;
      assign head_flags[c] = in_flags_i;
      assign hit[c]        = sel && (in_tag_i == hazard_tag_i);
      assign live[c]       = sel;
      assign rdy[c]        = grant[c] && out_ready_i;
    end else begin : g_pipe
      logic [LAT-1:0]     v_q;
      logic [TAG_W-1:0]   tag_q   [LAT];
      logic [DATA_W-1:0]  data_q  [LAT];
      logic [FLAGS_W-1:0] flags_q [LAT];
      logic               adv;
      logic               hit_l;

      // A blocked pipeline freezes as a whole; bubbles are kept in place.
      assign adv = !head_v[c] || (grant[c] && out_ready_i);

      always_ff @(posedge clk) begin
        if (rst || flush_i) begin
          v_q <= '0;
        end else if (adv) begin
          v_q[0] <= sel;
          for (int i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          tag_q[0]   <= in_tag_i;
          data_q[0]  <= in_data_i;
          flags_q[0] <= in_flags_i;
          for (int i = 1; i < LAT; i++) begin
            tag_q[i]   <= tag_q[i-1];
            data_q[i]  <= data_q[i-1];
            flags_q[i] <= flags_q[i-1];
          end
        end
      end

      always_comb begin
        hit_l = 1'b0;
        for (int i = 0; i < LAT; i++) hit_l = hit_l | (v_q[i] && (tag_q[i] == hazard_tag_i));
      end

      assign head_v[c]     = v_q[LAT-1];
      assign head_tag[c]   = tag_q[LAT-1];
      assign head_data[c]  = data_q[LAT-1];
      assign head_flags[c] = flags_q[LAT-1];
      assign hit[c]        = hit_l;
      assign live[c]       = |v_q;
      assign rdy[c]        = adv;
    end
  end

  assign collide  = &head_v;
  assign grant[0] = head_v[0] && !(collide && OTH_WINS);
  assign grant[1] = head_v[1] && !(collide && !OTH_WINS);

  assign out_valid_o = (|head_v) && !flush_i;
  assign out_tag_o   = grant[1] ? head_tag[1]   : head_tag[0];
  assign out_data_o  = grant[1] ? head_data[1]  : head_data[0];
  assign out_flags_o = grant[1] ? head_flags[1] : head_flags[0];

  assign in_ready_o = flush_i || rdy[in_class_i];
  assign busy_o     = |live;
  assign hazard_o   = |hit;

`ifdef CV32E40P_FPU_LAT_STALLCNT_EN
  logic [31:0] stall_cnt_q;

  // The losing head of a collision counts, whether or not writeback is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (collide && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_fpu_lat_pipe.sv
// Directed bench for cv32e40p_fpu_lat_pipe across four latency configurations.
module tb_cv32e40p_fpu_lat_pipe;

`ifdef CV32E40P_FPU_LAT_STALLCNT_EN
  localparam logic [31:0] EXP_CNT1 = 32'd1;
`else
  localparam logic [31:0] EXP_CNT1 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_class, out_ready;
  logic [5:0]  in_tag, hz_tag;
  logic [31:0] in_data;
  logic [4:0]  in_flags;

  logic        ov [4];
  logic        ir [4];
  logic        hz [4];
  logic        bz [4];
  logic [5:0]  ot [4];
  logic [31:0] od [4];
  logic [31:0] sc [4];
  logic [4:0]  of_ [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_fpu_lat_pipe #(.ADDMUL_LAT(0), .OTHERS_LAT(0)) u00 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir[0]),
    .in_class_i(in_class), .in_tag_i(in_tag), .in_data_i(in_data), .in_flags_i(in_flags),
    .out_valid_o(ov[0]), .out_ready_i(out_ready), .out_tag_o(ot[0]), .out_data_o(od[0]),
    .out_flags_o(of_[0]), .hazard_tag_i(hz_tag), .hazard_o(hz[0]), .busy_o(bz[0]),
    .stall_cnt_o(sc[0]));

  cv32e40p_fpu_lat_pipe #(.ADDMUL_LAT(1), .OTHERS_LAT(2)) u12 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir[1]),
    .in_class_i(in_class), .in_tag_i(in_tag), .in_data_i(in_data), .in_flags_i(in_flags),
    .out_valid_o(ov[1]), .out_ready_i(out_ready), .out_tag_o(ot[1]), .out_data_o(od[1]),
    .out_flags_o(of_[1]), .hazard_tag_i(hz_tag), .hazard_o(hz[1]), .busy_o(bz[1]),
    .stall_cnt_o(sc[1]));

  cv32e40p_fpu_lat_pipe #(.ADDMUL_LAT(2), .OTHERS_LAT(0)) u2 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir[2]),
    .in_class_i(in_class), .in_tag_i(in_tag), .in_data_i(in_data), .in_flags_i(in_flags),
    .out_valid_o(ov[2]), .out_ready_i(out_ready), .out_tag_o(ot[2]), .out_data_o(od[2]),
    .out_flags_o(of_[2]), .hazard_tag_i(hz_tag), .hazard_o(hz[2]), .busy_o(bz[2]),
    .stall_cnt_o(sc[2]));

  cv32e40p_fpu_lat_pipe #(.ADDMUL_LAT(3), .OTHERS_LAT(1)) u3 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir[3]),
    .in_class_i(in_class), .in_tag_i(in_tag), .in_data_i(in_data), .in_flags_i(in_flags),
    .out_valid_o(ov[3]), .out_ready_i(out_ready), .out_tag_o(ot[3]), .out_data_o(od[3]),
    .out_flags_o(of_[3]), .hazard_tag_i(hz_tag), .hazard_o(hz[3]), .busy_o(bz[3]),
    .stall_cnt_o(sc[3]));

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_class = 1'b0; out_ready = 1'b1;
    in_tag = '0; hz_tag = '0; in_data = '0; in_flags = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov[k]); end
      checks++; if (bz[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", k, bz[k]); end
      checks++; if (hz[k] !== 1'b0) begin errors++; $display("FAIL reset_hazard[%0d]: got %b want 0", k, hz[k]); end
      checks++; if (sc[k] !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt[%0d]: got %h want 0", k, sc[k]); end
    end
  endtask

  task automatic test_passthrough();
    do_reset();
    in_valid = 1'b1; in_class = 1'b0; in_tag = 6'h05; in_data = 32'h3F80_0000; in_flags = 5'h01;
    #1;
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL pt_valid: got %b want 1", ov[0]); end
    checks++; if (ot[0] !== 6'h05) begin errors++; $display("FAIL pt_tag: got %h want 05", ot[0]); end
    checks++; if (od[0] !== 32'h3F80_0000) begin errors++; $display("FAIL pt_data: got %h want 3f800000", od[0]); end
    checks++; if (of_[0] !== 5'h01) begin errors++; $display("FAIL pt_flags: got %h want 01", of_[0]); end
    checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL pt_ready: got %b want 1", ir[0]); end
    checks++; if (bz[0] !== 1'b1) begin errors++; $display("FAIL pt_busy: got %b want 1", bz[0]); end
    next();
    in_class = 1'b1; in_tag = 6'h06; in_data = 32'h4000_0000; out_ready = 1'b0; hz_tag = 6'h06;
    #1;
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL pt_valid_noready: got %b want 1", ov[0]); end
    checks++; if (ot[0] !== 6'h06) begin errors++; $display("FAIL pt_tag_c1: got %h want 06", ot[0]); end
    checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL pt_ready_blocked: got %b want 0", ir[0]); end
    checks++; if (hz[0] !== 1'b1) begin errors++; $display("FAIL pt_hazard: got %b want 1", hz[0]); end
    next();
    in_valid = 1'b0;
    #1;
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL pt_idle_valid: got %b want 0", ov[0]); end
    checks++; if (bz[0] !== 1'b0) begin errors++; $display("FAIL pt_idle_busy: got %b want 0", bz[0]); end
  endtask

  task automatic test_collision();
    do_reset();
    in_valid = 1'b1; in_class = 1'b1; in_tag = 6'h0A;
    #1;
    checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL col_ready0: got %b want 1", ir[1]); end
    next();
    in_class = 1'b0; in_tag = 6'h0B;
    #1;
    checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL col_ready1: got %b want 1", ir[1]); end
    checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL col_valid1: got %b want 0", ov[1]); end
    next();
    in_tag = 6'h0C;
    #1;
    checks++; if (ov[1] !== 1'b1) begin errors++; $display("FAIL col_valid2: got %b want 1", ov[1]); end
    checks++; if (ot[1] !== 6'h0A) begin errors++; $display("FAIL col_tag2: got %h want 0a", ot[1]); end
    checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL col_ready2: got %b want 0", ir[1]); end
    next();
    #1;
    checks++; if (ot[1] !== 6'h0B) begin errors++; $display("FAIL col_tag3: got %h want 0b", ot[1]); end
    checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL col_ready3: got %b want 1", ir[1]); end
    checks++; if (sc[1] !== EXP_CNT1) begin errors++; $display("FAIL col_stall_cnt: got %h want %h", sc[1], EXP_CNT1); end
    next();
    in_valid = 1'b0;
    #1;
    checks++; if (ot[1] !== 6'h0C || ov[1] !== 1'b1) begin errors++; $display("FAIL col_tag4: got %h/%b want 0c/1", ot[1], ov[1]); end
    next();
    #1;
    checks++; if (ov[1] !== 1'b0 || bz[1] !== 1'b0) begin errors++; $display("FAIL col_drain: got valid %b busy %b want 0/0", ov[1], bz[1]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_class = 1'b0; in_tag = 6'h11;
    #1;
    checks++; if (ir[2] !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", ir[2]); end
    next();
    in_valid = 1'b0;
    #1;
    checks++; if (ov[2] !== 1'b0 || bz[2] !== 1'b1) begin errors++; $display("FAIL bp_stage1: got valid %b busy %b want 0/1", ov[2], bz[2]); end
    for (int k = 0; k < 3; k++) begin
      next();
      #1;
      checks++; if (ov[2] !== 1'b1 || ot[2] !== 6'h11) begin errors++; $display("FAIL bp_hold%0d: got %b/%h want 1/11", k, ov[2], ot[2]); end
      checks++; if (ir[2] !== 1'b0 || bz[2] !== 1'b1) begin errors++; $display("FAIL bp_stall%0d: got ready %b busy %b want 0/1", k, ir[2], bz[2]); end
    end
    next();
    out_ready = 1'b1;
    #1;
    checks++; if (ov[2] !== 1'b1 || ir[2] !== 1'b1) begin errors++; $display("FAIL bp_release: got valid %b ready %b want 1/1", ov[2], ir[2]); end
    next();
    #1;
    checks++; if (ov[2] !== 1'b0 || bz[2] !== 1'b0) begin errors++; $display("FAIL bp_after: got valid %b busy %b want 0/0", ov[2], bz[2]); end
  endtask

  task automatic test_hazard();
    do_reset();
    hz_tag = 6'h07; in_valid = 1'b1; in_class = 1'b0; in_tag = 6'h07;
    #1;
    checks++; if (hz[3] !== 1'b0) begin errors++; $display("FAIL hz_issue: got %b want 0", hz[3]); end
    for (int k = 1; k <= 3; k++) begin
      next();
      in_valid = 1'b0;
      #1;
      checks++; if (hz[3] !== 1'b1) begin errors++; $display("FAIL hz_pending%0d: got %b want 1", k, hz[3]); end
      checks++; if (ov[3] !== (k == 3)) begin errors++; $display("FAIL hz_valid%0d: got %b want %b", k, ov[3], (k == 3)); end
    end
    checks++; if (ot[3] !== 6'h07) begin errors++; $display("FAIL hz_tag: got %h want 07", ot[3]); end
    hz_tag = 6'h08;
    #1;
    checks++; if (hz[3] !== 1'b0) begin errors++; $display("FAIL hz_other_tag: got %b want 0", hz[3]); end
    next();
    hz_tag = 6'h07;
    #1;
    checks++; if (hz[3] !== 1'b0 || bz[3] !== 1'b0) begin errors++; $display("FAIL hz_cleared: got hz %b busy %b want 0/0", hz[3], bz[3]); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_class = 1'b0; in_tag = 6'h21;
    next();
    in_tag = 6'h22;
    next();
    flush = 1'b1; in_tag = 6'h23;
    #1;
    checks++; if (ov[2] !== 1'b0 || ir[2] !== 1'b1) begin errors++; $display("FAIL fl_pipe: got valid %b ready %b want 0/1", ov[2], ir[2]); end
    checks++; if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin errors++; $display("FAIL fl_comb: got valid %b ready %b want 0/1", ov[0], ir[0]); end
    next();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (bz[2] !== 1'b0) begin errors++; $display("FAIL fl_busy: got %b want 0", bz[2]); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (ov[2] !== 1'b0) begin errors++; $display("FAIL fl_no_wb%0d: got %b want 0", k, ov[2]); end
      next();
      #1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_class = 1'b0; in_tag = 6'h31;
    next();
    in_tag = 6'h32;
    next();
    in_tag = 6'h33;
    #1;
    checks++; if (ov[2] !== 1'b1 || ot[2] !== 6'h31) begin errors++; $display("FAIL b2b_0: got %b/%h want 1/31", ov[2], ot[2]); end
    next();
    in_class = 1'b1; in_tag = 6'h40;
    #1;
    checks++; if (ot[2] !== 6'h32 || ir[2] !== 1'b0) begin errors++; $display("FAIL b2b_1: got %h ready %b want 32/0", ot[2], ir[2]); end
    next();
    #1;
    checks++; if (ot[2] !== 6'h33 || ir[2] !== 1'b0) begin errors++; $display("FAIL b2b_2: got %h ready %b want 33/0", ot[2], ir[2]); end
    next();
    #1;
    checks++; if (ot[2] !== 6'h40 || ir[2] !== 1'b1) begin errors++; $display("FAIL b2b_3: got %h ready %b want 40/1", ot[2], ir[2]); end
    next();
    in_valid = 1'b0;
    #1;
    checks++; if (ov[2] !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", ov[2]); end
  endtask

`ifdef CV32E40P_FPU_LAT_STALLCNT_EN
  task automatic test_stall_sat();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_class = 1'b1; in_tag = 6'h0A;
    next();
    in_class = 1'b0; in_tag = 6'h0B;
    next();
    in_valid = 1'b0;
    force u12.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u12.stall_cnt_q;
    #1;
    checks++; if (sc[1] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload: got %h want fffffffe", sc[1]); end
    for (int k = 0; k < 2; k++) begin
      next();
      #1;
      checks++; if (sc[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_cnt%0d: got %h want ffffffff", k, sc[1]); end
    end
    rst = 1'b1;
    next();
    #1;
    checks++; if (sc[1] !== 32'd0 || ov[1] !== 1'b0) begin errors++; $display("FAIL sat_rst: got %h/%b want 0/0", sc[1], ov[1]); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_class = 1'b0; out_ready = 1'b1;
    in_tag = '0; hz_tag = '0; in_data = '0; in_flags = '0;
    test_reset();
    test_passthrough();
    test_collision();
    test_backpressure();
    test_hazard();
    test_flush();
    test_back_to_back();
`ifdef CV32E40P_FPU_LAT_STALLCNT_EN
    test_stall_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
